// File: rtl/pll_lock_controller.sv
// rtl/pll_lock_controller.sv - PLL lock sequencer: reset hold, windowed frequency compare, lock/loss/fail tracking
module pll_lock_controller #(
    parameter int WINDOW          = 16,
    parameter int TOL             = 1,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT_WINDOWS = 64,
    parameter int HOLD_CYCLES     = 32,
    parameter int REF_TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       reference_clk_digital,
    input  logic       feedback_div_clk_digital,
    output logic       pll_reset_out,
    output logic       lock_digital,
    output logic       busy,
    output logic       fail,
    output logic       loss_of_lock,
    output logic [7:0] freq_error,
    output logic [2:0] state_digital
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = $clog2(TIMEOUT_WINDOWS + 1);
    localparam int WD_W   = $clog2(REF_TIMEOUT + 1);

    localparam logic signed [9:0] WINDOW_S = 10'(WINDOW);
    localparam logic signed [9:0] TOL_S    = 10'(TOL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              ref_q, fb_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        ref_cnt_q, ref_cnt_d;
    logic [7:0]        fb_cnt_q, fb_cnt_d;
    logic [GOOD_W-1:0] good_q, good_d, good_next;
    logic [WIN_W-1:0]  win_q, win_d, win_next;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        ferr_q, ferr_d;
    logic              lol_q, lol_d;

    // Edge detection and window arithmetic shared by the FSM below
    logic              ref_edge, fb_edge, win_close, good_win, wd_expire;
    logic [7:0]        fb_total;
    logic signed [9:0] diff;
    logic [7:0]        diff_clamped;

    assign ref_edge  = reference_clk_digital & ~ref_q;
    assign fb_edge   = feedback_div_clk_digital & ~fb_q;
    // A feedback edge in the closing cycle belongs to the closing window
    assign fb_total  = (fb_edge && (fb_cnt_q != 8'hFF)) ? fb_cnt_q + 8'd1 : fb_cnt_q;
    assign diff      = $signed({2'b00, fb_total}) - WINDOW_S;
    assign win_close = ref_edge && (ref_cnt_q == 8'(WINDOW - 1));
    assign good_win  = (diff <= TOL_S) && (diff >= -TOL_S);
    assign wd_expire = !ref_edge && (wd_q == WD_W'(REF_TIMEOUT - 1));
    assign diff_clamped = (diff > 10'sd127)  ? 8'h7F :
                          (diff < -10'sd128) ? 8'h80 : diff[7:0];

    // Next-state and counter updates for the lock sequence
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ref_cnt_d = ref_cnt_q;
        fb_cnt_d  = fb_cnt_q;
        good_d    = good_q;
        win_d     = win_q;
        wd_d      = wd_q;
        ferr_d    = ferr_q;
        lol_d     = 1'b0;
        good_next = good_win ? good_q + 1'b1 : '0;
        win_next  = win_q + 1'b1;
        case (state_q)
            IDLE, FAIL: begin
                if (start) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                ref_cnt_d = '0;
                fb_cnt_d  = '0;
                good_d    = '0;
                win_d     = '0;
                wd_d      = '0;
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = MEASURE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            MEASURE, LOCKED: begin
                fb_cnt_d = fb_total;
                wd_d     = ref_edge ? '0 : wd_q + 1'b1;
                if (ref_edge) begin
                    ref_cnt_d = ref_cnt_q + 8'd1;
                end
                if (win_close) begin
                    ref_cnt_d = '0;
                    fb_cnt_d  = '0;
                    ferr_d    = diff_clamped;
                    if (state_q == MEASURE) begin
                        good_d = good_next;
                        win_d  = win_next;
                        // Lock completion wins over timeout on the same close
                        if (good_next == GOOD_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end else if (win_next == WIN_W'(TIMEOUT_WINDOWS)) begin
                            state_d = FAIL;
                        end
                    end else if (!good_win) begin
                        state_d = MEASURE;
                        good_d  = '0;
                        win_d   = '0;
                        lol_d   = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d = FAIL;
                    lol_d   = (state_q == LOCKED);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts silently into IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ref_q     <= 1'b0;
            fb_q      <= 1'b0;
            hold_q    <= '0;
            ref_cnt_q <= '0;
            fb_cnt_q  <= '0;
            good_q    <= '0;
            win_q     <= '0;
            wd_q      <= '0;
            ferr_q    <= '0;
            lol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= reference_clk_digital;
            fb_q      <= feedback_div_clk_digital;
            hold_q    <= hold_d;
            ref_cnt_q <= ref_cnt_d;
            fb_cnt_q  <= fb_cnt_d;
            good_q    <= good_d;
            win_q     <= win_d;
            wd_q      <= wd_d;
            ferr_q    <= ferr_d;
            lol_q     <= lol_d;
        end
    end

    assign pll_reset_out = (state_q == IDLE) || (state_q == HOLD) || (state_q == FAIL);
    assign busy          = (state_q == HOLD) || (state_q == MEASURE) || (state_q == LOCKED);
    assign lock_digital  = (state_q == LOCKED);
    assign fail          = (state_q == FAIL);
    assign loss_of_lock  = lol_q;
    assign freq_error    = ferr_q;
    assign state_digital = state_q;

endmodule

// File: tb/tb_pll_lock_controller.sv
// tb/tb_pll_lock_controller.sv - directed scoreboard bench for pll_lock_controller
module tb_pll_lock_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ref_clk = 1'b0;
    logic       fb_clk = 1'b0;
    logic       pll_reset_out, lock_digital, busy, fail, loss_of_lock;
    logic [7:0] freq_error;
    logic [2:0] state_digital;

    pll_lock_controller dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .reference_clk_digital    (ref_clk),
        .feedback_div_clk_digital (fb_clk),
        .pll_reset_out            (pll_reset_out),
        .lock_digital             (lock_digital),
        .busy                     (busy),
        .fail                     (fail),
        .loss_of_lock             (loss_of_lock),
        .freq_error               (freq_error),
        .state_digital            (state_digital)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              tag;
        logic signed [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ph = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   hold_n = 0;
    int   lol_cnt = 0;
    bit   lock_seen = 0;
    bit   ref_en = 1;
    bit   fb_stop = 0;
    int   fb_extra = 0;

    task automatic push(input string tag, input logic signed [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic signed [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Reference: period 8 clk, high for 4. Feedback follows reference, plus
    // fb_extra extra pulses per 128-cycle span, or stays low when stopped.
    task automatic tick();
        @(negedge clk);
        ref_clk = ref_en && ((ph % 8) < 4);
        fb_clk  = !fb_stop && (ref_clk || ((((ph % 128) / 8) < fb_extra) && ((ph % 8) == 5)));
        ph++;
        @(posedge clk);
        #1;
        cyc++;
        if (lock_digital) lock_seen = 1;
        if (loss_of_lock) lol_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc - t0 < n) tick();
    endtask

    task automatic align_start();
        while ((ph % 128) != 0) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        lock_seen = 0;
        lol_cnt = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        push("rst_state", 0); push("rst_pll_reset", 1); push("rst_busy", 0);
        push("rst_lock", 0); push("rst_fail", 0); push("rst_lol", 0); push("rst_ferr", 0);
        chk(32'(state_digital)); chk(32'(pll_reset_out)); chk(32'(busy));
        chk(32'(lock_digital)); chk(32'(fail)); chk(32'(loss_of_lock));
        chk(32'($signed(freq_error)));
        reset = 1'b1;
        tick();

        // Equal frequency: 32-cycle hold, lock on 4th window close
        fb_extra = 0;
        align_start();
        push("hold_cycles", 32); push("measure_state", 2); push("measure_pll_reset", 0);
        hold_n = 0;
        while (state_digital == 3'd1 && pll_reset_out && hold_n < 100) begin
            hold_n++;
            tick();
        end
        chk(32'(hold_n)); chk(32'(state_digital)); chk(32'(pll_reset_out));
        push("lock_early", 0);
        run_to(543);
        chk(32'(lock_digital));
        push("lock_on_time", 1); push("locked_state", 3); push("locked_ferr", 0); push("locked_busy", 1);
        run_to(544);
        chk(32'(lock_digital)); chk(32'(state_digital));
        chk(32'($signed(freq_error))); chk(32'(busy));

        // Feedback stopped while locked
        fb_stop = 1;
        push("lol_early", 0);
        run_to(671);
        chk(32'(loss_of_lock));
        push("lol_pulse", 1); push("lol_lock", 0); push("lol_state", 2); push("lol_ferr", -16);
        run_to(672);
        chk(32'(loss_of_lock)); chk(32'(lock_digital)); chk(32'(state_digital));
        chk(32'($signed(freq_error)));
        push("lol_single", 1);
        run_to(680);
        chk(32'(lol_cnt));

        // 18 feedback edges per window: timeout after window 64
        reset_pulse();
        fb_stop = 0;
        fb_extra = 2;
        align_start();
        push("to_fail_early", 0); push("to_state_early", 2);
        run_to(8223);
        chk(32'(fail)); chk(32'(state_digital));
        push("to_fail", 1); push("to_state", 4); push("to_ferr", 2);
        push("to_pll_reset", 1); push("to_never_locked", 0);
        run_to(8224);
        chk(32'(fail)); chk(32'(state_digital)); chk(32'($signed(freq_error)));
        chk(32'(pll_reset_out)); chk(32'(lock_seen));
        push("fail_ferr_hold", 2); push("fail_sticky", 1);
        run_to(8240);
        chk(32'($signed(freq_error))); chk(32'(fail));

        // Restart from FAIL, lock, then reference held low
        fb_extra = 0;
        align_start();
        push("restart_state", 1); push("restart_fail", 0);
        chk(32'(state_digital)); chk(32'(fail));
        push("relock", 1);
        run_to(544);
        chk(32'(lock_digital));
        ref_en = 0;
        lol_cnt = 0;
        push("wd_early_fail", 0); push("wd_early_state", 3);
        run_to(544 + 1023);
        chk(32'(fail)); chk(32'(state_digital));
        push("wd_fail", 1); push("wd_lol", 1); push("wd_pll_reset", 1); push("wd_lock", 0);
        run_to(544 + 1024);
        chk(32'(fail)); chk(32'(loss_of_lock)); chk(32'(pll_reset_out)); chk(32'(lock_digital));
        push("wd_lol_single", 1);
        run_to(544 + 1030);
        chk(32'(lol_cnt));
        ref_en = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        push("wd_restart_state", 1); push("wd_restart_fail", 0);
        chk(32'(state_digital)); chk(32'(fail));

        // 17 feedback edges with coincident closing edges: windows good
        reset_pulse();
        fb_extra = 1;
        align_start();
        push("p1_lock_early", 0);
        run_to(543);
        chk(32'(lock_digital));
        push("p1_lock", 1); push("p1_ferr", 1);
        run_to(544);
        chk(32'(lock_digital)); chk(32'($signed(freq_error)));

        // Start ignored in MEASURE; asynchronous reset mid-MEASURE
        reset_pulse();
        fb_extra = 3;
        align_start();
        push("m_ferr", 3); push("m_state", 2);
        run_to(200);
        chk(32'($signed(freq_error))); chk(32'(state_digital));
        start = 1'b1;
        tick();
        start = 1'b0;
        push("start_ignored", 2);
        chk(32'(state_digital));
        reset = 1'b0;
        #2;
        push("ar_state", 0); push("ar_pll_reset", 1); push("ar_busy", 0); push("ar_lock", 0);
        push("ar_fail", 0); push("ar_lol", 0); push("ar_ferr", 0);
        chk(32'(state_digital)); chk(32'(pll_reset_out)); chk(32'(busy)); chk(32'(lock_digital));
        chk(32'(fail)); chk(32'(loss_of_lock)); chk(32'($signed(freq_error)));
        @(negedge clk);
        reset = 1'b1;
        tick();
        push("release_idle", 0);
        chk(32'(state_digital));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
